// File: rtl/laser_flag_packer.sv
// Laser sample packer: ACC/tb flagging, 32-bit word formatting and an FWFT output FIFO.
// Define LASER_SCAN_TRAILER_EN to append a {8'hA5, sample_cnt} trailer word to every scan.
module laser_flag_packer #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  laser_start_i,
  input  logic                  motor_zero_flag_i,
  input  logic                  acc_defect_en_i,
  input  logic [SAMPLE_W-1:0]   acc_defect_thre_i,
  input  logic [3:0]            afs_i,
  input  logic [3:0]            gain_i,
  input  logic                  laser_vld_i,
  input  logic [2*SAMPLE_W-1:0] laser_data_i,
  output logic [31:0]           m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [CNT_W-1:0]      fifo_count_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRST = 2'd1, S_RUN = 2'd2, S_TRAIL = 2'd3} state_t;

`ifdef LASER_SCAN_TRAILER_EN
  localparam state_t END_ST = S_TRAIL;
  logic [23:0]          r_sample_cnt;
`else
  localparam state_t END_ST = S_IDLE;
`endif

  state_t               r_state;
  logic                 r_start_d;
  logic                 r_s1_vld, r_s1_tb, r_s1_en;
  logic [SAMPLE_W:0]    r_s1_abs;
  logic [SAMPLE_W-1:0]  r_s1_thre, r_s1_act;
  logic [3:0]           r_s1_afs, r_s1_gain;
  logic                 r_s2_vld;
  logic [31:0]          r_s2_word;
  logic [31:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;
  logic [15:0]          r_drop_cnt;

  logic                 w_start_rise, w_start_fall, w_scan_start, w_accept;
  logic [SAMPLE_W:0]    w_diff, w_abs;
  logic                 w_acc;
  logic [15:0]          w_act16;
  logic                 w_full, w_empty, w_rd, w_trl_wr, w_wr_req, w_wr_ok, w_drop;
  logic [31:0]          w_wr_data;

  assign w_start_rise = laser_start_i & ~r_start_d;
  assign w_start_fall = ~laser_start_i & r_start_d;
  assign w_scan_start = w_start_rise & (r_state == S_IDLE);
  assign w_accept     = laser_vld_i & ((r_state == S_FIRST) | (r_state == S_RUN));
  assign w_diff       = {1'b0, laser_data_i[SAMPLE_W-1:0]} - {1'b0, laser_data_i[2*SAMPLE_W-1:SAMPLE_W]};
  assign w_abs        = w_diff[SAMPLE_W] ? ((SAMPLE_W+1)'(0) - w_diff) : w_diff;
  assign w_acc        = r_s1_en & ~r_s1_tb & (r_s1_abs > {1'b0, r_s1_thre});
  assign w_act16      = 16'(r_s1_act);
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == CNT_W'(0));
  assign w_rd         = ~w_empty & m_ready_i;
  assign w_wr_ok      = w_wr_req & (~w_full | w_rd);
  assign w_drop       = r_s2_vld & ~w_wr_ok;

  // FIFO write-port source: pipeline word, or the trailer once the pipeline has drained
  always_comb begin
    w_trl_wr  = 1'b0;
    w_wr_req  = r_s2_vld;
    w_wr_data = r_s2_word;
`ifdef LASER_SCAN_TRAILER_EN
    if ((r_state == S_TRAIL) && !r_s1_vld && !r_s2_vld && !w_full) begin
      w_trl_wr  = 1'b1;
      w_wr_req  = 1'b1;
      w_wr_data = {8'hA5, r_sample_cnt};
    end else begin
      w_trl_wr  = 1'b0;
    end
`endif
  end

  // Scan FSM, start edge detector, overflow/drop bookkeeping and sample counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
`ifdef LASER_SCAN_TRAILER_EN
      r_sample_cnt <= 24'd0;
`endif
    end else begin
      r_start_d <= laser_start_i;
      case (r_state)
        S_IDLE:  r_state <= w_start_rise ? S_FIRST : S_IDLE;
        S_FIRST: begin
          if (w_start_fall)           r_state <= END_ST;
          else if (motor_zero_flag_i) r_state <= S_RUN;
          else                        r_state <= S_FIRST;
        end
        S_RUN:   r_state <= w_start_fall ? END_ST : S_RUN;
        S_TRAIL: r_state <= w_trl_wr ? S_IDLE : S_TRAIL;
        default: r_state <= S_IDLE;
      endcase
      if (w_scan_start) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= 16'd0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
`ifdef LASER_SCAN_TRAILER_EN
      if (w_scan_start)                                r_sample_cnt <= 24'd0;
      else if (w_accept && r_sample_cnt != 24'hFFFFFF) r_sample_cnt <= r_sample_cnt + 24'd1;
`endif
    end
  end

  // Two-stage datapath: |actual-pre| with the tb tag taken from the state at entry, then word format
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      r_s2_vld <= r_s1_vld;
    end
    r_s1_tb   <= (r_state == S_FIRST);
    r_s1_en   <= acc_defect_en_i;
    r_s1_abs  <= w_abs;
    r_s1_thre <= acc_defect_thre_i;
    r_s1_act  <= laser_data_i[SAMPLE_W-1:0];
    r_s1_afs  <= afs_i;
    r_s1_gain <= gain_i;
    r_s2_word <= {r_s1_tb, w_acc, 2'b00, r_s1_afs, r_s1_gain, 4'b0000, w_act16};
  end

  // FIFO storage (no reset needed: contents are only visible while count is non-zero)
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) r_mem[r_wptr] <= w_wr_data;
  end

  // FIFO pointers and occupancy; a write at full succeeds when a read frees a slot in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd)    r_rptr <= r_rptr + AW'(1);
      case ({w_wr_ok, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_data_o     = w_empty ? 32'd0 : r_mem[r_rptr];
  assign m_valid_o    = ~w_empty;
  assign fifo_count_o = r_count;
  assign overflow_o   = r_overflow;
  assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_laser_flag_packer.sv
// Scoreboard bench for laser_flag_packer: expected words queued at stimulus, compared at FIFO output.
module tb_laser_flag_packer;

  localparam int SW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, zero_flag = 1'b0, en = 1'b0, vld = 1'b0, ready = 1'b0;
  logic [SW-1:0] thre = '0;
  logic [3:0]    afs = 4'h0, gain = 4'h0;
  logic [2*SW-1:0] data = '0;
  logic [31:0]   m_data;
  logic          m_valid, overflow;
  logic [CW-1:0] fifo_count;
  logic [15:0]   drop_cnt;

  int            n_total = 0;
  int            n_bad   = 0;
  logic [31:0]   sb[$];
  bit            m_first = 1'b0;
  bit            m_scan  = 1'b0;
  int            m_cnt   = 0;

  laser_flag_packer #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .laser_start_i(start), .motor_zero_flag_i(zero_flag),
    .acc_defect_en_i(en), .acc_defect_thre_i(thre), .afs_i(afs), .gain_i(gain),
    .laser_vld_i(vld), .laser_data_i(data), .m_data_o(m_data), .m_valid_o(m_valid),
    .m_ready_i(ready), .fifo_count_o(fifo_count), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One sample pair; keep=0 marks a word the bench expects the full FIFO to drop
  task automatic send(input logic [15:0] act, input logic [15:0] pre, input bit zero, input bit keep);
    int a, p, ad;
    bit acc;
    a = act; p = pre;
    ad = (a > p) ? (a - p) : (p - a);
    acc = en && !m_first && (ad > int'(thre));
    vld = 1'b1; data = {pre, act}; zero_flag = zero;
    if (m_scan) begin
      if (keep) sb.push_back({m_first, acc, 2'b00, afs, gain, 4'h0, act});
      if (m_cnt < 24'hFFFFFF) m_cnt++;
    end
    tick();
    vld = 1'b0; zero_flag = 1'b0;
    if (zero && m_scan) m_first = 1'b0;
  endtask

  task automatic start_scan(input bit zero);
    start = 1'b1; zero_flag = zero;
    tick();
    zero_flag = 1'b0;
    m_first = 1'b1; m_scan = 1'b1; m_cnt = 0;
  endtask

  task automatic pulse_zero;
    zero_flag = 1'b1;
    tick();
    zero_flag = 1'b0;
    m_first = 1'b0;
  endtask

  task automatic stop_scan;
    start = 1'b0;
    tick();
    m_scan = 1'b0;
`ifdef LASER_SCAN_TRAILER_EN
    sb.push_back({8'hA5, 24'(m_cnt)});
`endif
  endtask

  task automatic drain;
    ready = 1'b1;
    for (int i = 0; i < 400 && (sb.size() != 0 || m_valid); i++) tick();
    check_eq("drain_left", 32'(sb.size()), 32'd0);
    check_eq("drain_count", 32'(fifo_count), 32'd0);
  endtask

  // Output monitor: every accepted word is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!rst && m_valid && ready) begin
      if (sb.size() == 0) check_eq("unexpected_word", 32'd0, 32'd1);
      else check_eq("word", m_data, sb.pop_front());
    end
  end

  initial begin
    int sent;
    tick(); tick(); tick();
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_data", m_data, 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Pre-RUN samples, ACC threshold boundary, enable off, field packing
    ready = 1'b1; en = 1'b1; thre = 16'h0010;
    start_scan(1'b0);
    for (int i = 0; i < 4; i++) send(16'h0100, 16'h0000, 1'b0, 1'b1);
    send(16'h0100, 16'h0000, 1'b1, 1'b1);
    send(16'h0110, 16'h0100, 1'b0, 1'b1);
    send(16'h0111, 16'h0100, 1'b0, 1'b1);
    send(16'h0100, 16'h0111, 1'b0, 1'b1);
    en = 1'b0;
    send(16'h0111, 16'h0100, 1'b0, 1'b1);
    send(16'h0100, 16'h0111, 1'b0, 1'b1);
    afs = 4'hA; gain = 4'h3;
    send(16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
    idle(1);
    stop_scan();
    drain();

    // Rise with zero flag in the same cycle; 10 samples, trailer held until the consumer resumes
    ready = 1'b0; en = 1'b1;
    start_scan(1'b1);
    for (int i = 0; i < 10; i++) send(16'(i * 3), 16'(i), 1'b0, 1'b1);
    stop_scan();
    idle(6);
    check_eq("held_count", 32'(fifo_count), 32'd11 - (m_scan ? 32'd0 : 32'd0)
`ifndef LASER_SCAN_TRAILER_EN
             - 32'd1
`endif
             );
    drain();

    // Overflow: DEPTH+3 samples into a stalled FIFO
    ready = 1'b0;
    start_scan(1'b0);
    pulse_zero();
    for (int i = 0; i < DEPTH + 3; i++) send(16'(16'h0200 + i), 16'h0000, 1'b0, i < DEPTH);
    idle(4);
    check_eq("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_drop", 32'(drop_cnt), 32'd3);
    stop_scan();
    idle(5);
    check_eq("ovf_full_hold", 32'(fifo_count), 32'(DEPTH));
    drain();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // New scan clears overflow; reset mid-scan flushes the FIFO without a trailer
    ready = 1'b0;
    start_scan(1'b0);
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    check_eq("clr_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 3; i++) send(16'h0033, 16'h0011, 1'b0, 1'b1);
    idle(3);
    check_eq("pre_rst_count", 32'(fifo_count), 32'd3);
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    sb.delete(); m_scan = 1'b0; m_first = 1'b0;
    rst = 1'b0;
    idle(4);
    check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
    check_eq("mid_rst_valid", 32'(m_valid), 32'd0);

    // Random backpressure; sends are throttled so the FIFO can never fill
    start_scan(1'b0);
    pulse_zero();
    sent = 0;
    for (int i = 0; i < 20000 && sent < 1000; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if (sb.size() < DEPTH - 4 && $urandom_range(0, 1) == 1) begin
        en = 1'($urandom); thre = 16'($urandom_range(0, 255));
        afs = 4'($urandom); gain = 4'($urandom);
        send(16'($urandom_range(0, 511)), 16'($urandom_range(0, 511)), 1'b0, 1'b1);
        sent++;
      end else begin
        idle(1);
      end
    end
    check_eq("rand_sent", 32'(sent), 32'd1000);
    stop_scan();
    drain();
    check_eq("rand_ovf", 32'(overflow), 32'd0);
    check_eq("rand_drop", 32'(drop_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
